// File: rtl/multi_port_fifo.sv
// Multi-port in-order FIFO: up to WR_PORTS pushes and RD_PORTS pops per cycle.
// The oldest RD_PORTS entries are presented first-word-fall-through on rd_data.
module multi_port_fifo #(
  parameter type T         = logic [31:0],
  parameter int  DEPTH     = 16,
  parameter int  WR_PORTS  = 2,
  parameter int  RD_PORTS  = 2,
  parameter int  AF_THRESH = DEPTH - 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [$clog2(WR_PORTS+1)-1:0] wr_num,
  input  T                              wr_data [WR_PORTS],
  output logic                          wr_ready,
  output T                              rd_data [RD_PORTS],
  output logic [RD_PORTS-1:0]           rd_valid,
  input  logic [$clog2(RD_PORTS+1)-1:0] rd_pop,
  output logic [$clog2(DEPTH):0]        count,
  output logic [$clog2(DEPTH):0]        free,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EXT_W = PTR_W + 2;
  localparam int WN_W  = $clog2(WR_PORTS + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic [EXT_W-1:0] push_amt;
  logic [EXT_W-1:0] pop_req;
  logic [EXT_W-1:0] pop_amt;
  logic [EXT_W-1:0] count_next;

  // Push acceptance looks only at the registered count, so a same-cycle pop
  // never opens room and wr_ready has no input-to-output path.
  always_comb begin
    push_ok    = wr_ready && !flush && !reset;
    push_amt   = push_ok ? EXT_W'(wr_num) : '0;
    pop_req    = EXT_W'(rd_pop);
    pop_amt    = (pop_req > EXT_W'(count)) ? EXT_W'(count) : pop_req;
    count_next = EXT_W'(count) + push_amt - pop_amt;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_amt);
      wr_ptr <= wr_ptr + PTR_W'(push_amt);
      count  <= CNT_W'(count_next);
    end
  end

  // Storage holds no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      for (int j = 0; j < WR_PORTS; j++) begin
        if (WN_W'(j) < wr_num) begin
          mem[wr_ptr + PTR_W'(j)] <= wr_data[j];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_data[i]  = mem[rd_ptr + PTR_W'(i)];
      rd_valid[i] = count > CNT_W'(i);
    end
  end

  assign free        = CNT_W'(DEPTH) - count;
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_W'(AF_THRESH));
  assign wr_ready    = (free >= CNT_W'(WR_PORTS));

endmodule

// File: tb/tb_multi_port_fifo.sv
// Scoreboard bench for multi_port_fifo (DEPTH=8, 2 write lanes, 2 read lanes, AF_THRESH=6).
module tb_multi_port_fifo;

  localparam int DEPTH = 8;
  localparam int WRP   = 2;
  localparam int RDP   = 2;
  localparam int AFT   = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  wr_num = '0;
  logic [31:0] wr_data [WRP];
  logic        wr_ready;
  logic [31:0] rd_data [RDP];
  logic [1:0]  rd_valid;
  logic [1:0]  rd_pop = '0;
  logic [3:0]  count;
  logic [3:0]  free;
  logic        full;
  logic        empty;
  logic        almost_full;

  multi_port_fifo #(
    .DEPTH(DEPTH), .WR_PORTS(WRP), .RD_PORTS(RDP), .AF_THRESH(AFT)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_num(wr_num), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .rd_pop(rd_pop),
    .count(count), .free(free), .full(full), .empty(empty), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset) assert (wr_num <= 2'(WRP)) else $error("illegal wr_num %0d", wr_num);

  typedef struct {
    bit          known;
    bit          drop;
    int          cnt;
    logic [31:0] v0;
    logic [31:0] v1;
    int          pop;
  } rec_t;

  rec_t        rec_q [$];
  logic [31:0] model_q [$];
  logic [31:0] got_q [$];
  bit          known = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares the registered-state outputs against the expectation the
  // driver issued for this cycle, and collects the entries actually consumed.
  always @(negedge clk) begin
    rec_t r;
    int   n;
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      if (r.known) begin
        check("count", 32'(count), 32'(r.cnt));
        check("free", 32'(free), 32'(DEPTH - r.cnt));
        check("empty", 32'(empty), 32'(r.cnt == 0));
        check("full", 32'(full), 32'(r.cnt == DEPTH));
        check("almost_full", 32'(almost_full), 32'(r.cnt >= AFT));
        check("wr_ready", 32'(wr_ready), 32'((DEPTH - r.cnt) >= WRP));
        check("rd_valid", 32'(rd_valid), {30'd0, r.cnt > 1, r.cnt > 0});
        if (r.cnt > 0) check("rd_data0", rd_data[0], r.v0);
        if (r.cnt > 1) check("rd_data1", rd_data[1], r.v1);
        if (!r.drop) begin
          n = (r.pop < r.cnt) ? r.pop : r.cnt;
          for (int i = 0; i < n; i++) got_q.push_back(rd_data[i]);
        end
      end
    end
  end

  // Driver: applies one cycle of stimulus and advances the reference queue.
  task automatic cyc(input bit rs, input bit fl, input int wn, input logic [31:0] d0,
                     input logic [31:0] d1, input int pop, output bit acc);
    rec_t r;
    int   sz;
    int   n;
    reset = rs; flush = fl; wr_num = 2'(wn);
    wr_data[0] = d0; wr_data[1] = d1; rd_pop = 2'(pop);
    sz = model_q.size();
    r.known = known; r.drop = rs || fl; r.cnt = sz; r.pop = pop;
    r.v0 = (sz > 0) ? model_q[0] : '0;
    r.v1 = (sz > 1) ? model_q[1] : '0;
    rec_q.push_back(r);
    acc = 1'b0;
    if (rs || fl) begin
      model_q.delete();
      known = 1'b1;
    end else begin
      acc = (DEPTH - sz) >= WRP;
      n = (pop < sz) ? pop : sz;
      repeat (n) void'(model_q.pop_front());
      if (acc && wn > 0) model_q.push_back(d0);
      if (acc && wn > 1) model_q.push_back(d1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit fl, input int wn, input int pop);
    bit a;
    cyc(1'b0, fl, wn, $urandom, $urandom, pop, a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit a;
    int nxt;
    int iters;
    int wn;
    wr_data[0] = '0;
    wr_data[1] = '0;
    @(posedge clk);
    #1;
    // Reset held two cycles, then idle to observe reset values.
    cyc(1'b1, 1'b0, 0, 0, 0, 0, a);
    cyc(1'b1, 1'b0, 0, 0, 0, 0, a);
    step(1'b0, 0, 0);
    // Two-lane push then single pop.
    cyc(1'b0, 1'b0, 2, 32'hA0, 32'hB1, 0, a);
    step(1'b0, 0, 1);
    step(1'b0, 0, 0);
    // Fill and backpressure.
    step(1'b1, 0, 0);
    step(1'b0, 2, 0);
    step(1'b0, 2, 0);
    step(1'b0, 2, 0);
    step(1'b0, 1, 0);
    step(1'b0, 1, 0);
    step(1'b0, 0, 1);
    step(1'b0, 2, 0);
    step(1'b0, 2, 0);
    step(1'b0, 1, 0);
    step(1'b0, 0, 0);
    // Concurrent push and pop at count 3.
    step(1'b1, 0, 0);
    step(1'b0, 2, 0);
    step(1'b0, 1, 0);
    step(1'b0, 2, 2);
    step(1'b0, 0, 2);
    step(1'b0, 0, 1);
    // Random stream of 40 sequential values across several pointer wraps.
    step(1'b1, 0, 0);
    got_q.delete();
    nxt = 0;
    iters = 0;
    while ((nxt < 40 || model_q.size() > 0) && iters < 2000) begin
      wn = (nxt < 40) ? int'($urandom_range(2, 0)) : 0;
      if (nxt + wn > 40) wn = 40 - nxt;
      cyc(1'b0, 1'b0, wn, 32'(nxt), 32'(nxt + 1), int'($urandom_range(2, 0)), a);
      if (a) nxt += wn;
      iters++;
    end
    step(1'b0, 0, 0);
    check("stream_done", 32'(iters < 2000), 32'd1);
    check("stream_len", 32'(got_q.size()), 32'd40);
    for (int k = 0; k < 40 && k < got_q.size(); k++) check("stream_order", got_q[k], 32'(k));
    // Flush with a simultaneous push, then pop clamping at low occupancy.
    step(1'b0, 2, 0);
    step(1'b0, 2, 0);
    step(1'b0, 1, 0);
    step(1'b1, 2, 1);
    step(1'b0, 0, 0);
    step(1'b0, 1, 0);
    step(1'b0, 0, 2);
    step(1'b0, 0, 2);
    step(1'b0, 0, 0);
    // Reset mid-stream, then a push landing at pointer 0.
    step(1'b0, 2, 0);
    step(1'b0, 2, 1);
    cyc(1'b1, 1'b0, 2, $urandom, $urandom, 1, a);
    step(1'b0, 2, 0);
    step(1'b0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(rec_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_port_fifo.md
# multi_port_fifo

Parametrised multi-port FIFO, successor to the team's single-port FIFO, for superscalar frontend/backend queues (fetch-to-decode instruction queue, dispatch buffers). Accepts up to WR_PORTS entries and retires up to RD_PORTS entries per cycle, in strict program order. The oldest RD_PORTS entries are presented first-word-fall-through. A synchronous flush supports branch-mispredict recovery. Occupancy outputs drive backpressure into the producer stage.

## Interface
- T, logic [31:0]: entry type.
- DEPTH, 16: entries. Must be a power of two and at least max(WR_PORTS, RD_PORTS).
- WR_PORTS, 2: maximum pushes per cycle.
- RD_PORTS, 2: maximum pops per cycle.
- AF_THRESH, DEPTH-4: almost_full asserts when count >= AF_THRESH.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high. Clears the FIFO.
- flush  in  1  synchronous discard of all contents.
- wr_num  in  $clog2(WR_PORTS+1)  number of entries pushed this cycle; lanes 0..wr_num-1 are used.
- wr_data  in  T [WR_PORTS]  push data; lane 0 is the oldest.
- wr_ready  out  1  free >= WR_PORTS.
- rd_data  out  T [RD_PORTS]  lane i carries the i-th oldest entry.
- rd_valid  out  RD_PORTS  bit i = (count > i).
- rd_pop  in  $clog2(RD_PORTS+1)  number of oldest entries consumed this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.
- free  out  $clog2(DEPTH)+1  DEPTH - count.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.

## Operation
- State:
  - circular storage of DEPTH entries;
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH;
  - count register.
  - Storage is not reset.
- Push:
  - Accepted only when wr_ready=1 and flush=0. Acceptance is all-or-nothing.
  - wr_ready is computed from the current count only; a same-cycle pop does not create room.
  - When accepted, lane j is written to storage[(wr_ptr+j) mod DEPTH] for j < wr_num, and wr_ptr advances by wr_num.
  - When wr_ready=0, the push is ignored with no state change. The producer must hold its data.
  - wr_num > WR_PORTS is illegal; the bench asserts against it.
- Pop:
  - Effective pop = min(rd_pop, count), so pops are clamped and never underflow.
  - rd_ptr advances by the effective pop.
  - rd_data[i] = storage[(rd_ptr+i) mod DEPTH]; this is combinational from the registers.
  - rd_data lanes with rd_valid[i]=0 are don't-care.
- Count update: count_next = count + accepted push − effective pop. Compute in $clog2(DEPTH)+2 bits; the result always lies in 0..DEPTH.
- Simultaneous push and pop: both apply in the same cycle. Pops read pre-edge contents, so a pop never returns an entry pushed in the same cycle.
- Priority: reset > flush > push/pop.
  - flush=1 sets rd_ptr=wr_ptr=0 and count=0.
  - Pushes and pops in a flush cycle are discarded.

## Timing
- Reset values, visible in the cycle after reset is sampled high:
  - count=0, free=DEPTH;
  - empty=1, full=0, almost_full=0 (AF_THRESH>0);
  - rd_valid=0, wr_ready=1.
- Push-to-visible latency is 1 cycle: data pushed at edge N appears on rd_data and rd_valid after edge N.
- Pop takes effect at the edge. The next entries shift into lane 0 in the following cycle.
- Flush or reset mid-stream empties the FIFO in one cycle. The first push after it lands at pointer 0.
- All status outputs are registered-derived with no combinational path from any input:
  - count, free, full, empty, almost_full, wr_ready, rd_valid.
- rd_data depends only on registers.

## Test plan
Configuration for all scenarios: DEPTH=8, WR_PORTS=2, RD_PORTS=2, AF_THRESH=6.

1. Reset:
   - Stimulus: hold reset 2 cycles, then release.
   - Required: count=0, free=8, empty=1, full=0, rd_valid=2'b00, wr_ready=1.
2. Two-lane push:
   - Stimulus: wr_num=2, data {0xA0, 0xB1}.
   - Required next cycle: count=2, rd_valid=2'b11, rd_data[0]=0xA0, rd_data[1]=0xB1.
   - Stimulus: rd_pop=1.
   - Required: rd_data[0]=0xB1, rd_valid=2'b01.
3. Fill and backpressure:
   - Stimulus: push 2 per cycle from empty.
   - Required: almost_full=1 at count=6.
   - Required: at count=7, wr_ready=0 and a wr_num=1 push is ignored (count stays 7).
   - Required: pop 1, then push 2, gives count=8, full=1, wr_ready=0.
   - Required: further pushes are ignored and count stays 8.
4. Concurrent traffic:
   - Stimulus: at count=3, apply wr_num=2 and rd_pop=2 in the same cycle.
   - Required: count=3 next cycle, and the output order matches the reference queue.
5. Wrap-around:
   - Stimulus: stream 40 entries (values 0..39) with random wr_num (0–2) and rd_pop (0–2).
   - Required: pops return exactly 0..39 in order across multiple pointer wraps.
   - Required: count equals the scoreboard occupancy every cycle.
6. Flush and clamping:
   - Stimulus: at count=5, assert flush together with wr_num=2.
   - Required next cycle: count=0, empty=1, rd_valid=0, and no pushed data appears.
   - Stimulus: at count=1, apply rd_pop=2.
   - Required: count=0, with no underflow.
